div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider for the M extension (DIV, DIVU, REM, REMU).
- Sits in the execute stage beside the ALU and MUL unit.
- Takes operands and a `div_ops_e` opcode from issue; returns one `data_bus_t` result plus its destination register tag to writeback.
- Reports occupancy to the issue logic with `fu_state_e`.

Parameters:
- `XLEN`, default 32: operand/result width; counter width is $clog2(XLEN)+1.
- `REG_WIDTH`, default 5: width of the destination register tag.

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  synchronous, active-high reset
- `flush_i`  in  1  abort the current operation (pipeline flush / trap)
- `valid_i`  in  1  issue strobe; operands, opcode and tag valid
- `op_i`  in  2  `div_ops_e`: `DIV_`, `DIVU_`, `REM_`, `REMU_`
- `dividend_i`  in  XLEN  rs1 value
- `divisor_i`  in  XLEN  rs2 value
- `rd_i`  in  REG_WIDTH  destination register tag
- `state_o`  out  1  `fu_state_e`: `FREE` only in IDLE, else `BUSY`
- `valid_o`  out  1  result strobe, exactly one cycle wide
- `result_o`  out  XLEN  quotient or remainder (`data_bus_t`)
- `rd_o`  out  REG_WIDTH  tag captured at accept

Behaviour:
- Reset (`rst_i`=1 at a clock edge):
  - state goes to IDLE; `valid_o`=0, `result_o`=0, `rd_o`=0, `state_o`=`FREE`, counter=0.
  - Reset overrides `flush_i` and `valid_i`; reset mid-operation discards all work.
- Accept:
  - Accept happens only when state is IDLE and `valid_i`=1 at a clock edge; `valid_i` in any other state is ignored.
  - On accept, register the opcode, operands and `rd_i`.
  - Signed op = `DIV_`/`REM_`.
- States and transitions:
  - IDLE -> DONE on accept of a special case.
  - IDLE -> PREP on accept of a normal case.
  - PREP -> DIVIDE after 1 cycle.
  - DIVIDE -> FIX when the counter reaches 0.
  - FIX -> DONE.
  - DONE -> IDLE.
- Special cases (fast path, decided combinationally at accept):
  - Divisor = 0: quotient = all ones, remainder = dividend (all four ops).
  - Signed op, dividend = 0x80000000, divisor = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Latency: `valid_o` is high in the cycle after the accept edge (1 cycle).
- PREP:
  - Signed ops: take the absolute value of both operands.
  - Record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Unsigned ops: use operands as-is, `neg_q` = `neg_r` = 0.
  - Clear the partial remainder (XLEN+1 bits); counter = XLEN-1.
- DIVIDE (restoring, one bit per cycle, exactly XLEN cycles):
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor. If trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
  - Decrement the counter; leave on the cycle it reads 0.
- FIX:
  - Select the quotient (`DIV_`/`DIVU_`) or the remainder (`REM_`/`REMU_`).
  - Two's-complement negate if `neg_q` (quotient) or `neg_r` (remainder).
  - Register the result into `result_o`.
- DONE:
  - `valid_o`=1 for exactly this cycle.
  - `result_o` and `rd_o` stay stable until the next accept; `valid_o`=0 in every other state.
- Normal-case latency: `valid_o` is high 34 cycles after the accept edge (PREP 1 + DIVIDE 32 + FIX 1).
- Throughput: a new op can be accepted at the earliest in the cycle after DONE.
- Flush:
  - `flush_i`=1 in any state (no reset) forces IDLE at the next edge.
  - In DONE, it also forces `valid_o`=0 in that same cycle (`valid_o` is gated by `!flush_i`).
  - A flush concurrent with `valid_i` in IDLE: flush wins, nothing is accepted.
- Sign rule: the remainder takes the sign of the dividend; quotient truncates toward zero (RISC-V semantics).

Test Plan:
- `DIV_` 100 / -7 -> `result_o`=0xFFFFFFF2 (-14), `valid_o` 34 cycles after accept, `rd_o`=tag; `REM_` same operands -> 0x00000002.
- `DIVU_` 0xFFFFFFFF / 2 -> 0x7FFFFFFF; `REMU_` -> 1; `REM_` -7 / 2 -> 0xFFFFFFFF (-1).
- `DIV_` 5 / 0 -> 0xFFFFFFFF with 1-cycle latency; `REM_` 5 / 0 -> 5; `DIV_` 0x80000000 / 0xFFFFFFFF -> 0x80000000, `REM_` -> 0, both 1-cycle.
- Back-to-back: hold `valid_i` high continuously -> second accept occurs only in IDLE after DONE; `state_o`=`BUSY` throughout the op; no lost or duplicated `valid_o`.
- `flush_i` pulsed 10 cycles into a DIVU -> no `valid_o`, `state_o`=`FREE` next cycle; new op 20/3 then returns 6.
- `rst_i` asserted mid-DIVIDE -> next cycle `valid_o`=0, `result_o`=0, `rd_o`=0, `state_o`=`FREE`; subsequent op completes correctly.

Source files
------------

// File: rtl/div_unit_if.sv
// Shared opcode/occupancy types and the issue/writeback interface of the iterative divider.
// The package sits here so the interface and the divider both see the same enums.
package div_unit_pkg;
    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

interface div_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_WIDTH = 5
);
    import div_unit_pkg::*;

    typedef logic [XLEN-1:0] data_bus_t;

    logic                 flush_i;
    logic                 valid_i;
    div_ops_e             op_i;
    data_bus_t            dividend_i;
    data_bus_t            divisor_i;
    logic [REG_WIDTH-1:0] rd_i;
    fu_state_e            state_o;
    logic                 valid_o;
    data_bus_t            result_o;
    logic [REG_WIDTH-1:0] rd_o;

    modport master (
        output flush_i, valid_i, op_i, dividend_i, divisor_i, rd_i,
        input  state_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, dividend_i, divisor_i, rd_i,
        output state_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a one-cycle
// fast path for divide-by-zero and signed overflow.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        DIVIDE = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e               state_q, state_n;
    div_ops_e             op_q, op_n;
    logic [XLEN-1:0]      quo_q, quo_n;
    logic [XLEN-1:0]      dvs_q, dvs_n;
    logic [XLEN:0]        rem_q, rem_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic                 neg_quo_q, neg_quo_n;
    logic                 neg_rem_q, neg_rem_n;
    logic [XLEN-1:0]      result_q, result_n;
    logic [REG_WIDTH-1:0] rd_q, rd_n;
    logic                 valid_q, valid_n;
    fu_state_e            fu_q, fu_n;

    logic                 in_signed, in_rem, div_zero, overflow, special;
    logic [XLEN-1:0]      special_res;
    logic                 q_signed, q_rem;
    logic [XLEN:0]        shifted, trial;
    logic [XLEN-1:0]      fix_val;
    logic                 fix_neg;

    // Fast-path decode on the raw issue operands.
    always_comb begin
        in_signed   = (bus.op_i == DIV_) || (bus.op_i == REM_);
        in_rem      = (bus.op_i == REM_) || (bus.op_i == REMU_);
        div_zero    = (bus.divisor_i == '0);
        overflow    = in_signed && (bus.dividend_i == MIN_INT) && (&bus.divisor_i);
        special     = div_zero || overflow;
        special_res = '0;
        if (div_zero) begin
            special_res = in_rem ? bus.dividend_i : '1;
        end else if (overflow) begin
            special_res = in_rem ? '0 : MIN_INT;
        end
    end

    // One restoring step: quo shifts its MSB into rem, trial subtract decides the new bit.
    always_comb begin
        q_signed = (op_q == DIV_) || (op_q == REM_);
        q_rem    = (op_q == REM_) || (op_q == REMU_);
        shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial    = shifted - {1'b0, dvs_q};
        fix_val  = q_rem ? rem_q[XLEN-1:0] : quo_q;
        fix_neg  = q_rem ? neg_rem_q : neg_quo_q;
    end

    always_comb begin
        state_n   = state_q;
        op_n      = op_q;
        quo_n     = quo_q;
        dvs_n     = dvs_q;
        rem_n     = rem_q;
        cnt_n     = cnt_q;
        neg_quo_n = neg_quo_q;
        neg_rem_n = neg_rem_q;
        result_n  = result_q;
        rd_n      = rd_q;

        if (bus.flush_i) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_n  = bus.op_i;
                        quo_n = bus.dividend_i;
                        dvs_n = bus.divisor_i;
                        rd_n  = bus.rd_i;
                        if (special) begin
                            result_n = special_res;
                            state_n  = DONE;
                        end else begin
                            state_n  = PREP;
                        end
                    end
                end
                PREP: begin
                    if (q_signed) begin
                        quo_n     = quo_q[XLEN-1] ? -quo_q : quo_q;
                        dvs_n     = dvs_q[XLEN-1] ? -dvs_q : dvs_q;
                        neg_quo_n = quo_q[XLEN-1] ^ dvs_q[XLEN-1];
                        neg_rem_n = quo_q[XLEN-1];
                    end else begin
                        neg_quo_n = 1'b0;
                        neg_rem_n = 1'b0;
                    end
                    rem_n   = '0;
                    cnt_n   = CW'(XLEN - 1);
                    state_n = DIVIDE;
                end
                DIVIDE: begin
                    if (!trial[XLEN]) begin
                        rem_n = trial;
                        quo_n = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_n = shifted;
                        quo_n = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_n = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_n = FIX;
                    end
                end
                FIX: begin
                    result_n = fix_neg ? -fix_val : fix_val;
                    state_n  = DONE;
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        valid_n = (state_n == DONE);
        fu_n    = (state_n == IDLE) ? FREE : BUSY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= DIV_;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            fu_q      <= FREE;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            quo_q     <= quo_n;
            dvs_q     <= dvs_n;
            rem_q     <= rem_n;
            cnt_q     <= cnt_n;
            neg_quo_q <= neg_quo_n;
            neg_rem_q <= neg_rem_n;
            result_q  <= result_n;
            rd_q      <= rd_n;
            valid_q   <= valid_n;
            fu_q      <= fu_n;
        end
    end

    // A flush landing in DONE kills the result strobe in that same cycle.
    assign bus.valid_o  = valid_q & ~bus.flush_i;
    assign bus.state_o  = fu_q;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: normal and fast-path results, latency, back-to-back
// issue, flush and mid-operation reset, all with hand-computed expectations.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        div_ops_e    op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    div_unit_if bus ();

    div_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one op at a negedge with the unit idle; report what came back.
    task automatic run_op(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output int lat, output logic [31:0] res,
                          output logic [4:0] rd, output logic busy_ok, output logic tail_ok);
        bus.valid_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.rd_i       = tag;
        @(negedge clk);
        bus.valid_i    = 1'b0;
        bus.dividend_i = 32'h1234_5678;
        bus.divisor_i  = 32'h0000_0003;
        bus.rd_i       = ~tag;
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.valid_o !== 1'b1 && lat < 60) begin
            if (bus.state_o !== BUSY) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.state_o !== BUSY) busy_ok = 1'b0;
        res = bus.result_o;
        rd  = bus.rd_o;
        @(negedge clk);
        tail_ok = (bus.valid_o === 1'b0) && (bus.state_o === FREE) && (bus.result_o === res);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.op_i       = DIV_;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.rd_i       = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset valid_o: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL reset result_o: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.rd_o !== 5'd0) begin n_bad++; $display("FAIL reset rd_o: got %0d want 0", bus.rd_o); end
        n_cmp++; if (bus.state_o !== FREE) begin n_bad++; $display("FAIL reset state_o: got %b want FREE", bus.state_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        vec_t        v[14];
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        busy_ok, tail_ok;
        v[0]  = '{DIV_,  32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2};
        v[1]  = '{REM_,  32'd100,      32'hFFFF_FFF9, 32'h0000_0002};
        v[2]  = '{DIVU_, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF};
        v[3]  = '{REMU_, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001};
        v[4]  = '{REM_,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
        v[5]  = '{DIV_,  32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2};
        v[6]  = '{REM_,  32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE};
        v[7]  = '{DIV_,  32'h8000_0000, 32'd2,        32'hC000_0000};
        v[8]  = '{DIVU_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        v[9]  = '{REMU_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[10] = '{REM_,  32'd7,        32'd9,        32'h0000_0007};
        v[11] = '{DIV_,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003};
        v[12] = '{REM_,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        v[13] = '{DIVU_, 32'd20,       32'd3,        32'h0000_0006};
        for (int i = 0; i < 14; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), lat, res, rd, busy_ok, tail_ok);
            n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL normal[%0d] latency: got %0d want 34", i, lat); end
            n_cmp++; if (res !== v[i].exp) begin n_bad++; $display("FAIL normal[%0d] result: got %h want %h", i, res, v[i].exp); end
            n_cmp++; if (rd !== 5'(i + 1)) begin n_bad++; $display("FAIL normal[%0d] rd: got %0d want %0d", i, rd, i + 1); end
            n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL normal[%0d] busy: state_o left BUSY during op", i); end
            n_cmp++; if (tail_ok !== 1'b1) begin n_bad++; $display("FAIL normal[%0d] strobe: valid_o not one cycle or result unstable", i); end
        end
    endtask

    task automatic test_special();
        vec_t        v[6];
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        busy_ok, tail_ok;
        v[0] = '{DIV_,  32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{REM_,  32'd5,         32'd0,         32'h0000_0005};
        v[2] = '{DIVU_, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[3] = '{REMU_, 32'h8000_0000, 32'd0,         32'h8000_0000};
        v[4] = '{DIV_,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[5] = '{REM_,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 16), lat, res, rd, busy_ok, tail_ok);
            n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL special[%0d] latency: got %0d want 0", i, lat); end
            n_cmp++; if (res !== v[i].exp) begin n_bad++; $display("FAIL special[%0d] result: got %h want %h", i, res, v[i].exp); end
            n_cmp++; if (rd !== 5'(i + 16)) begin n_bad++; $display("FAIL special[%0d] rd: got %0d want %0d", i, rd, i + 16); end
            n_cmp++; if (tail_ok !== 1'b1) begin n_bad++; $display("FAIL special[%0d] strobe: valid_o not one cycle or result unstable", i); end
        end
    endtask

    task automatic test_back_to_back();
        int          pulses, lat1, lat2, free_cnt;
        logic [31:0] res1, res2;
        logic [4:0]  rd1, rd2;
        pulses = 0; lat1 = -1; lat2 = -1; free_cnt = 0;
        res1 = '0; res2 = '0; rd1 = '0; rd2 = '0;
        bus.valid_i = 1'b1; bus.op_i = DIVU_; bus.dividend_i = 32'd20; bus.divisor_i = 32'd3; bus.rd_i = 5'd3;
        @(negedge clk);
        // Swap operands while busy: the first op must keep its captured values.
        bus.op_i = DIV_; bus.dividend_i = 32'hFFFF_FFEC; bus.divisor_i = 32'd3; bus.rd_i = 5'd4;
        for (int k = 0; k <= 70; k++) begin
            if (bus.valid_o === 1'b1) begin
                pulses++;
                if (pulses == 1) begin lat1 = k; res1 = bus.result_o; rd1 = bus.rd_o; end
                else begin lat2 = k; res2 = bus.result_o; rd2 = bus.rd_o; end
            end
            if (bus.state_o === FREE) free_cnt++;
            if (k < 70) @(negedge clk);
        end
        bus.valid_i = 1'b0;
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b pulses: got %0d want 2", pulses); end
        n_cmp++; if (lat1 !== 34) begin n_bad++; $display("FAIL b2b first latency: got %0d want 34", lat1); end
        n_cmp++; if (res1 !== 32'd6) begin n_bad++; $display("FAIL b2b first result: got %h want 00000006", res1); end
        n_cmp++; if (rd1 !== 5'd3) begin n_bad++; $display("FAIL b2b first rd: got %0d want 3", rd1); end
        n_cmp++; if (lat2 !== 70) begin n_bad++; $display("FAIL b2b second latency: got %0d want 70", lat2); end
        n_cmp++; if (res2 !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL b2b second result: got %h want fffffffa", res2); end
        n_cmp++; if (rd2 !== 5'd4) begin n_bad++; $display("FAIL b2b second rd: got %0d want 4", rd2); end
        n_cmp++; if (free_cnt !== 1) begin n_bad++; $display("FAIL b2b free cycles: got %0d want 1", free_cnt); end
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.state_o !== FREE || bus.valid_o !== 1'b0) begin
            n_bad++; $display("FAIL b2b idle after drop: state %b valid %b want FREE/0", bus.state_o, bus.valid_o);
        end
    endtask

    task automatic test_flush();
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        busy_ok, tail_ok, seen;
        bus.valid_i = 1'b1; bus.op_i = DIVU_; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd7; bus.rd_i = 5'd9;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_cmp++; if (bus.state_o !== FREE) begin n_bad++; $display("FAIL flush state_o: got %b want FREE", bus.state_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL flush valid_o: got %b want 0", bus.valid_o); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.valid_o === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush ghost result: valid_o=%b after flushed op, want 0", seen); end
        run_op(DIVU_, 32'd20, 32'd3, 5'd10, lat, res, rd, busy_ok, tail_ok);
        n_cmp++; if (res !== 32'd6 || lat !== 34 || rd !== 5'd10) begin
            n_bad++; $display("FAIL flush recovery: got %h lat %0d rd %0d want 00000006 lat 34 rd 10", res, lat, rd);
        end

        // Flush in DONE masks the strobe combinationally.
        bus.valid_i = 1'b1; bus.op_i = DIV_; bus.dividend_i = 32'd5; bus.divisor_i = 32'd0; bus.rd_i = 5'd11;
        @(negedge clk);
        bus.valid_i = 1'b0;
        n_cmp++; if (bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL done strobe before flush: got %b want 1", bus.valid_o); end
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL done flush gate: got %b want 0", bus.valid_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_cmp++; if (bus.state_o !== FREE) begin n_bad++; $display("FAIL done flush state_o: got %b want FREE", bus.state_o); end

        // Flush together with issue in IDLE: nothing is taken.
        bus.valid_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = DIV_; bus.dividend_i = 32'd8; bus.divisor_i = 32'd0; bus.rd_i = 5'd12;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        n_cmp++; if (bus.state_o !== FREE) begin n_bad++; $display("FAIL idle flush state_o: got %b want FREE", bus.state_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL idle flush valid_o: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.rd_o !== 5'd11) begin n_bad++; $display("FAIL idle flush rd_o: got %0d want 11", bus.rd_o); end
    endtask

    task automatic test_reset_mid_op();
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        busy_ok, tail_ok, seen;
        bus.valid_i = 1'b1; bus.op_i = DIV_; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3; bus.rd_i = 5'd13;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst valid_o: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL midrst result_o: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.rd_o !== 5'd0) begin n_bad++; $display("FAIL midrst rd_o: got %0d want 0", bus.rd_o); end
        n_cmp++; if (bus.state_o !== FREE) begin n_bad++; $display("FAIL midrst state_o: got %b want FREE", bus.state_o); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.valid_o === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst ghost result: valid_o=%b after reset, want 0", seen); end
        run_op(REM_, 32'd1000, 32'd3, 5'd14, lat, res, rd, busy_ok, tail_ok);
        n_cmp++; if (res !== 32'd1 || lat !== 34 || rd !== 5'd14) begin
            n_bad++; $display("FAIL midrst recovery: got %h lat %0d rd %0d want 00000001 lat 34 rd 14", res, lat, rd);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_normal();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
